// File: rtl/huff_enc_ctrl.sv
// huff_enc_ctrl -- block sequencer for the Huffman encoder core.
//
// Loads BLOCK_LEN symbols from an upstream valid/ready source into the
// encoder. It then enables encoding, packs the encoder's serial bitstream
// MSB-first into bytes, and queues the bytes in a 4-entry FIFO for a
// downstream valid/ready consumer. At block end it pulses Done and reports
// the bit count.
//
// Handshakes: a transfer happens on every rising Clk edge where valid and
// ready are both high. Valid must not depend on ready in the same cycle.
// The encoder side has no backpressure. Enc_re marks each valid Enc_bit.
//
// Optional feature: define HUFF_CTRL_WATCHDOG_EN to build a watchdog over
// ARM/STREAM that aborts the block after TIMEOUT idle cycles.
//
// Ports:
//   Clk, Reset           clock (rising edge), async active-low reset
//   Start                begin a block (only sampled in IDLE)
//   Sym_valid/ready/data upstream symbol channel
//   Enc_en, Enc_wr_en,
//   Enc_data             encoder enable, symbol write strobe, symbol
//   Enc_bit, Enc_re      encoder serial bit and bit-valid
//   Byte_valid/ready/data downstream byte channel (FIFO head)
//   Busy, Done, Bit_count status: not-IDLE, block-end pulse, bits in block
//   Err_ovf, Err_timeout sticky FIFO overflow / watchdog flags
//   Dbg_state            current FSM state
module huff_enc_ctrl #(
    parameter int unsigned BLOCK_LEN = 16,
    parameter int unsigned SYM_W     = 4,
    parameter int unsigned TIMEOUT   = 1023
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Sym_valid,
    output logic             Sym_ready,
    input  logic [SYM_W-1:0] Sym_data,
    output logic             Enc_en,
    output logic             Enc_wr_en,
    output logic [SYM_W-1:0] Enc_data,
    input  logic             Enc_bit,
    input  logic             Enc_re,
    output logic             Byte_valid,
    input  logic             Byte_ready,
    output logic [7:0]       Byte_data,
    output logic             Busy,
    output logic             Done,
    output logic [15:0]      Bit_count,
    output logic             Err_ovf,
    output logic             Err_timeout,
    output logic [2:0]       Dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_ARM    = 3'd2,
        S_STREAM = 3'd3,
        S_FLUSH  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [7:0] SYM_LAST = 8'(BLOCK_LEN - 1);

    state_t      state, state_nxt;
    logic [7:0]  sym_cnt;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_pos;     // bits currently held in shreg (mod 8)
    logic [7:0]  shreg;
    logic        start_go, sym_hs, bit_take, pad_push, byte_push, wd_fire;
    logic [7:0]  push_data;
    logic [2:0]  pad_sh;

    // FIFO storage
    logic [7:0]  fifo_mem [4];
    logic [1:0]  rd_ptr, wr_ptr;
    logic [2:0]  fifo_cnt;
    logic        fifo_full, pop, do_write;

    assign start_go   = (state == S_IDLE) && Start;
    assign Sym_ready  = (state == S_LOAD);
    assign sym_hs     = Sym_valid && Sym_ready;
    assign Enc_en     = (state == S_LOAD) || (state == S_ARM) || (state == S_STREAM);
    assign Busy       = (state != S_IDLE);
    assign Done       = (state == S_DONE);
    assign Dbg_state  = state;

    // The residual k bits sit in the low end of shreg; shift them up by 8-k
    // to left-align them. (0 - k) mod 8 equals 8 - k for k in 1..7.
    assign pad_sh    = 3'd0 - bit_pos;
    assign byte_push = (bit_take && (bit_pos == 3'd7)) || pad_push;
    assign push_data = pad_push ? (shreg << pad_sh) : {shreg[6:0], Enc_bit};

    always_comb begin
        state_nxt = state;
        bit_take  = 1'b0;
        pad_push  = 1'b0;
        case (state)
            S_IDLE:   if (Start) state_nxt = S_LOAD;
            S_LOAD:   if (sym_hs && (sym_cnt == SYM_LAST)) state_nxt = S_ARM;
            S_ARM:    if (Enc_re) begin
                          bit_take  = 1'b1;
                          state_nxt = S_STREAM;
                      end
            S_STREAM: if (Enc_re) bit_take = 1'b1;
                      else        state_nxt = S_FLUSH;
            S_FLUSH:  if (bit_pos != 3'd0)    pad_push  = 1'b1;
                      else if (fifo_cnt == 3'd0) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (wd_fire) state_nxt = S_DONE;
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= S_IDLE;
            sym_cnt   <= '0;
            bit_cnt   <= '0;
            bit_pos   <= '0;
            shreg     <= '0;
            Enc_wr_en <= 1'b0;
            Enc_data  <= '0;
            Bit_count <= '0;
            Err_ovf   <= 1'b0;
        end else begin
            state     <= state_nxt;
            Enc_wr_en <= sym_hs;
            if (sym_hs) Enc_data <= Sym_data;
            if (start_go) begin
                sym_cnt <= '0;
                bit_cnt <= '0;
                bit_pos <= '0;
                shreg   <= '0;
                Err_ovf <= 1'b0;
            end else begin
                if (sym_hs) sym_cnt <= sym_cnt + 8'd1;
                if (bit_take) begin
                    shreg   <= {shreg[6:0], Enc_bit};
                    bit_pos <= bit_pos + 3'd1;
                    if (bit_cnt != 16'hFFFF) bit_cnt <= bit_cnt + 16'd1;
                end else if (pad_push) begin
                    bit_pos <= '0;
                end
                if (byte_push && fifo_full && !pop) Err_ovf <= 1'b1;
            end
            // Latch on entry so Bit_count is already valid during Done.
            if ((state_nxt == S_DONE) && (state != S_DONE)) Bit_count <= bit_cnt;
        end
    end

    // Byte FIFO. A push while full is accepted only if a pop frees the
    // head slot in the same cycle; otherwise the byte is dropped.
    assign fifo_full  = (fifo_cnt == 3'd4);
    assign Byte_valid = (fifo_cnt != 3'd0);
    assign Byte_data  = fifo_mem[rd_ptr];
    assign pop        = Byte_valid && Byte_ready;
    assign do_write   = byte_push && (!fifo_full || pop);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else if (wd_fire) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (do_write) begin
                fifo_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 2'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + {2'b00, do_write} - {2'b00, pop};
        end
    end

`ifdef HUFF_CTRL_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_run;

    assign wd_run  = (state == S_ARM) || (state == S_STREAM);
    // Fires on the TIMEOUT-th consecutive cycle without Enc_re.
    assign wd_fire = wd_run && !Enc_re && (wd_cnt == WD_W'(TIMEOUT - 1));

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wd_cnt      <= '0;
            Err_timeout <= 1'b0;
        end else begin
            if (!wd_run || Enc_re) wd_cnt <= '0;
            else                   wd_cnt <= wd_cnt + 1'b1;
            if (start_go)     Err_timeout <= 1'b0;
            else if (wd_fire) Err_timeout <= 1'b1;
        end
    end
`else
    assign wd_fire     = 1'b0;
    assign Err_timeout = 1'b0;
`endif

endmodule
